// File: rtl/note_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_pkg : shared types and field slices for the chart sequencer
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
package note_pkg;

  localparam int NOTE_W  = 16;
  localparam int TIME_W  = 14;
  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int TIME_HI = 13;
  localparam int TIME_LO = 0;

  typedef enum logic [1:0] {
    TAP       = 2'b00,
    HOLD_HEAD = 2'b01,
    HOLD_TAIL = 2'b10,
    END       = 2'b11
  } note_type_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    PERFECT = 2'b01,
    GOOD    = 2'b10,
    MISS    = 2'b11
  } judge_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic note_type_t note_type(input logic [NOTE_W-1:0] n);
    return note_type_t'(n[TYPE_HI:TYPE_LO]);
  endfunction

  function automatic logic [TIME_W-1:0] note_time(input logic [NOTE_W-1:0] n);
    return n[TIME_HI:TIME_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_sched_if : chart ROM, timing/key inputs and HUD outputs of note_sched
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
interface note_sched_if;
  import note_pkg::*;

  logic                frame_tick;
  logic                start;
  logic                key;
  logic [NOTE_W-1:0]   head_note;
  logic [7:0]          addr;
  logic [TIME_W-1:0]   frame_cnt;
  logic                judge_valid;
  logic [1:0]          judge_code;
  logic [9:0]          combo;
  logic [9:0]          max_combo;
  logic [15:0]         score;
  logic                holding;
  logic                busy;
  logic                done;

  modport master (
    output frame_tick, start, key, head_note,
    input  addr, frame_cnt, judge_valid, judge_code, combo, max_combo,
           score, holding, busy, done
  );

  modport slave (
    input  frame_tick, start, key, head_note,
    output addr, frame_cnt, judge_valid, judge_code, combo, max_combo,
           score, holding, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/note_sched_judge_window.sv
`default_nettype none
// ---------------------------------------------------------------------------
// judge_window : classifies frame_cnt - t against the PERFECT/GOOD windows
// Rev 1.0      : initial release
// ---------------------------------------------------------------------------
module judge_window
  import note_pkg::*;
#(
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6
) (
  input  logic [TIME_W-1:0] frame_cnt,
  input  logic [TIME_W-1:0] t,
  input  logic              press,
  output logic              early,
  output logic              perfect,
  output logic              good,
  output logic              late,
  output logic              reached
);

  localparam int DW = TIME_W + 1;
  localparam logic signed [DW-1:0] PW = DW'(PERFECT_WIN);
  localparam logic signed [DW-1:0] GW = DW'(GOOD_WIN);

  logic signed [DW-1:0] diff;
  logic                 in_perfect;
  logic                 in_good;

  assign diff       = $signed({1'b0, frame_cnt}) - $signed({1'b0, t});
  assign in_perfect = (diff >= -PW) && (diff <= PW);
  assign in_good    = (diff >= -GW) && (diff <= GW);

  // early/late/reached are ungated so the hold-tail check can use them on key level
  assign early   = diff < -GW;
  assign late    = diff > GW;
  assign reached = ~diff[DW-1];
  assign perfect = press & in_perfect;
  assign good    = press & in_good & ~in_perfect;

endmodule
`default_nettype wire

// File: rtl/note_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_sched : chart sequencer and hit judge with score/combo tracking
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
module note_sched
  import note_pkg::*;
#(
  parameter int NOTE_COUNT  = 111,
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6
) (
  input  logic         Clk,
  input  logic         Reset,
  note_sched_if.slave  bus
);

  localparam logic [7:0]        LAST_ADDR = 8'(NOTE_COUNT);
  localparam logic [9:0]        COMBO_MAX = '1;
  localparam logic [15:0]       SCORE_MAX = '1;
  localparam logic [TIME_W-1:0] FRAME_MAX = '1;

  state_t            state;
  logic              key_d;
  logic              press;
  note_type_t        ntype;
  logic [TIME_W-1:0] t;
  logic              early, perfect, good, late, reached;
  logic              at_end;
  judge_t            verdict;
  logic [1:0]        adv;
  logic [8:0]        addr_sum;
  logic [7:0]        addr_next;
  logic [9:0]        combo_next;
  logic [15:0]       score_next;

  assign press  = bus.key & ~key_d;
  assign ntype  = note_type(bus.head_note);
  assign t      = note_time(bus.head_note);
  assign at_end = (bus.addr == LAST_ADDR) || (ntype == END);

  judge_window #(
    .PERFECT_WIN (PERFECT_WIN),
    .GOOD_WIN    (GOOD_WIN)
  ) u_window (
    .frame_cnt (bus.frame_cnt),
    .t         (t),
    .press     (press),
    .early     (early),
    .perfect   (perfect),
    .good      (good),
    .late      (late),
    .reached   (reached)
  );

  always_comb begin
    verdict = NONE;
    adv     = 2'd0;
    case (state)
      S_PLAY: begin
        if (!at_end) begin
          if (ntype == HOLD_TAIL) begin
            adv = 2'd1;
          end else if (late) begin
            verdict = MISS;
            adv     = (ntype == HOLD_HEAD) ? 2'd2 : 2'd1;
          end else if (perfect) begin
            verdict = PERFECT;
            adv     = 2'd1;
          end else if (good) begin
            verdict = GOOD;
            adv     = 2'd1;
          end
        end
      end
      S_HOLD: begin
        // reaching the tail wins even if the key drops on that same cycle
        if (reached) begin
          verdict = PERFECT;
          adv     = 2'd1;
        end else if (!bus.key) begin
          verdict = early ? MISS : GOOD;
          adv     = 2'd1;
        end
      end
      default: begin
        verdict = NONE;
        adv     = 2'd0;
      end
    endcase
  end

  assign addr_sum  = {1'b0, bus.addr} + {7'd0, adv};
  assign addr_next = (addr_sum > {1'b0, LAST_ADDR}) ? LAST_ADDR : addr_sum[7:0];

  always_comb begin
    combo_next = bus.combo;
    score_next = bus.score;
    case (verdict)
      PERFECT: begin
        combo_next = (bus.combo == COMBO_MAX) ? COMBO_MAX : bus.combo + 10'd1;
        score_next = (bus.score >= SCORE_MAX - 16'd1) ? SCORE_MAX : bus.score + 16'd2;
      end
      GOOD: begin
        combo_next = (bus.combo == COMBO_MAX) ? COMBO_MAX : bus.combo + 10'd1;
        score_next = (bus.score == SCORE_MAX) ? SCORE_MAX : bus.score + 16'd1;
      end
      MISS:    combo_next = 10'd0;
      default: combo_next = bus.combo;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= S_IDLE;
      key_d           <= 1'b0;
      bus.addr        <= '0;
      bus.frame_cnt   <= '0;
      bus.judge_valid <= 1'b0;
      bus.judge_code  <= 2'b00;
      bus.combo       <= '0;
      bus.max_combo   <= '0;
      bus.score       <= '0;
      bus.holding     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      key_d           <= bus.key;
      bus.judge_valid <= 1'b0;

      if ((state == S_PLAY || state == S_HOLD) && bus.frame_tick && bus.frame_cnt != FRAME_MAX)
        bus.frame_cnt <= bus.frame_cnt + 1'b1;

      if (adv != 2'd0)
        bus.addr <= addr_next;

      if (verdict != NONE) begin
        bus.judge_valid <= 1'b1;
        bus.judge_code  <= verdict;
        bus.combo       <= combo_next;
        bus.score       <= score_next;
        if (combo_next > bus.max_combo)
          bus.max_combo <= combo_next;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state         <= S_PLAY;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.holding   <= 1'b0;
            bus.addr      <= '0;
            bus.frame_cnt <= '0;
            bus.combo     <= '0;
            bus.max_combo <= '0;
            bus.score     <= '0;
          end
        end
        S_PLAY: begin
          if (at_end) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else if ((verdict == PERFECT || verdict == GOOD) && ntype == HOLD_HEAD) begin
            state       <= S_HOLD;
            bus.holding <= 1'b1;
          end
        end
        S_HOLD: begin
          if (verdict != NONE) begin
            state       <= S_PLAY;
            bus.holding <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_sched.sv
`default_nettype none
// Bench for note_sched: directed scenarios plus random charts checked against
// a behavioural per-cycle model of the judging rules.
module tb_note_sched;

  localparam int NC = 111;
  localparam int PW = 3;
  localparam int GW = 6;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic key = 1'b0;
  logic [15:0] rom [0:255];

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 play, 2 hold, 3 done
  int m_mode, m_addr, m_frame, m_combo, m_max, m_score, m_jv, m_jc;
  bit m_key;

  always #5 Clk = ~Clk;

  note_sched_if bus ();
  note_sched_if bus2 ();

  assign bus.frame_tick  = frame_tick;
  assign bus.start       = start;
  assign bus.key         = key;
  assign bus.head_note   = rom[bus.addr];
  assign bus2.frame_tick = frame_tick;
  assign bus2.start      = start;
  assign bus2.key        = key;
  assign bus2.head_note  = rom[bus2.addr];

  note_sched #(.NOTE_COUNT(NC), .PERFECT_WIN(PW), .GOOD_WIN(GW)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave));

  note_sched #(.NOTE_COUNT(2), .PERFECT_WIN(PW), .GOOD_WIN(GW)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(bus2.slave));

  task automatic model_step();
    logic [15:0] h;
    int ty, t, d, v, adv, nm;
    bit pr;
    pr = key && !m_key;
    if (Reset) begin
      m_mode = 0; m_addr = 0; m_frame = 0; m_combo = 0; m_max = 0;
      m_score = 0; m_jv = 0; m_jc = 0; m_key = 0;
      return;
    end
    h  = rom[m_addr[7:0]];
    ty = int'(h[15:14]);
    t  = int'(h[13:0]);
    d  = m_frame - t;
    v = 0; adv = 0; nm = m_mode;
    if (m_mode == 0 || m_mode == 3) begin
      if (start) begin
        nm = 1; m_addr = 0; m_frame = 0; m_combo = 0; m_max = 0; m_score = 0;
      end
    end else if (m_mode == 1) begin
      if (m_addr == NC || ty == 3) nm = 3;
      else if (ty == 2) adv = 1;
      else if (d > GW) begin v = 3; adv = (ty == 1) ? 2 : 1; end
      else if (pr && d >= -PW && d <= PW) begin v = 1; adv = 1; if (ty == 1) nm = 2; end
      else if (pr && d >= -GW) begin v = 2; adv = 1; if (ty == 1) nm = 2; end
    end else begin
      if (d >= 0) v = 1;
      else if (!key) v = (d < -GW) ? 3 : 2;
      if (v != 0) begin adv = 1; nm = 1; end
    end
    if ((m_mode == 1 || m_mode == 2) && frame_tick && m_frame < 16383) m_frame++;
    m_addr = (m_addr + adv > NC) ? NC : m_addr + adv;
    m_jv = (v != 0) ? 1 : 0;
    if (v != 0) begin
      m_jc = v;
      if (v == 3) m_combo = 0;
      else begin
        m_combo = (m_combo + 1 > 1023) ? 1023 : m_combo + 1;
        m_score = (m_score + (v == 1 ? 2 : 1) > 65535) ? 65535 : m_score + (v == 1 ? 2 : 1);
      end
      if (m_combo > m_max) m_max = m_combo;
    end
    m_mode = nm;
    m_key = key;
  endtask

  task automatic clk1();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
  endtask

  task automatic do_reset();
    Reset = 1'b1; start = 1'b0; key = 1'b0; frame_tick = 1'b0;
    clk1();
    Reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  task automatic goto_frame(input int f);
    for (int i = 0; i < 20000 && m_frame < f; i++) begin
      frame_tick = 1'b1;
      clk1();
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    clk1();
    checks++;
    if ({bus.addr, bus.frame_cnt, bus.judge_valid, bus.judge_code, bus.combo, bus.max_combo,
         bus.score, bus.holding, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset: addr=%0d frame=%0d jv=%b jc=%b combo=%0d max=%0d score=%0d h/b/d=%b%b%b, want all 0",
               bus.addr, bus.frame_cnt, bus.judge_valid, bus.judge_code, bus.combo, bus.max_combo,
               bus.score, bus.holding, bus.busy, bus.done);
    end
    Reset = 1'b0;
  endtask

  task automatic test_tap_perfect();
    clear_rom();
    rom[0] = 16'h0047;
    do_reset();
    do_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.addr !== 8'd0 || bus.frame_cnt !== 14'd0) begin
      errors++;
      $display("FAIL start: busy=%b addr=%0d frame=%0d, want 1 0 0", bus.busy, bus.addr, bus.frame_cnt);
    end
    goto_frame(71);
    checks++;
    if (bus.frame_cnt !== 14'd71 || bus.judge_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_count: frame=%0d jv=%b, want 71 0", bus.frame_cnt, bus.judge_valid);
    end
    key = 1'b1;
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge_code !== 2'b01 || bus.addr !== 8'd1 ||
        bus.score !== 16'd2 || bus.combo !== 10'd1) begin
      errors++;
      $display("FAIL tap_perfect: jv=%b jc=%b addr=%0d score=%0d combo=%0d, want 1 01 1 2 1",
               bus.judge_valid, bus.judge_code, bus.addr, bus.score, bus.combo);
    end
    key = 1'b0;
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b0 || bus.judge_code !== 2'b01 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL end_done: jv=%b jc=%b done=%b busy=%b, want 0 01 1 0",
               bus.judge_valid, bus.judge_code, bus.done, bus.busy);
    end
  endtask

  task automatic test_tap_good_and_ignore();
    clear_rom();
    rom[0] = 16'h0047;
    do_reset();
    do_start();
    goto_frame(66);
    key = 1'b1;
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge_code !== 2'b10 || bus.score !== 16'd1 || bus.addr !== 8'd1) begin
      errors++;
      $display("FAIL tap_good: jv=%b jc=%b score=%0d addr=%0d, want 1 10 1 1",
               bus.judge_valid, bus.judge_code, bus.score, bus.addr);
    end
    key = 1'b0;
    do_reset();
    do_start();
    goto_frame(60);
    key = 1'b1;
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b0 || bus.addr !== 8'd0 || bus.score !== 16'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tap_early_ignored: jv=%b addr=%0d score=%0d busy=%b, want 0 0 0 1",
               bus.judge_valid, bus.addr, bus.score, bus.busy);
    end
    key = 1'b0;
  endtask

  task automatic test_miss_combo();
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = 16'(10 * (i + 1));
    rom[5] = 16'h0047;
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      goto_frame(10 * (i + 1));
      key = 1'b1; clk1();
      key = 1'b0; clk1();
    end
    goto_frame(78);
    checks++;
    if (bus.judge_valid !== 1'b0 || bus.combo !== 10'd5 || bus.score !== 16'd10 || bus.addr !== 8'd5) begin
      errors++;
      $display("FAIL pre_miss: jv=%b combo=%0d score=%0d addr=%0d, want 0 5 10 5",
               bus.judge_valid, bus.combo, bus.score, bus.addr);
    end
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge_code !== 2'b11 || bus.combo !== 10'd0 ||
        bus.max_combo !== 10'd5 || bus.addr !== 8'd6) begin
      errors++;
      $display("FAIL tap_miss: jv=%b jc=%b combo=%0d max=%0d addr=%0d, want 1 11 0 5 6",
               bus.judge_valid, bus.judge_code, bus.combo, bus.max_combo, bus.addr);
    end
  endtask

  // release_at: 0 = hold through the tail, otherwise the frame the key drops
  task automatic test_hold(input int release_at, input logic [1:0] exp_code,
                           input int exp_score, input int exp_combo, input int exp_max);
    clear_rom();
    rom[0] = 16'h4064;
    rom[1] = 16'h8078;
    do_reset();
    do_start();
    goto_frame(100);
    key = 1'b1;
    clk1();
    checks++;
    if (bus.judge_code !== 2'b01 || bus.addr !== 8'd1 || bus.holding !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_head: jc=%b addr=%0d holding=%b busy=%b, want 01 1 1 1",
               bus.judge_code, bus.addr, bus.holding, bus.busy);
    end
    if (release_at == 0) begin
      goto_frame(120);
    end else begin
      goto_frame(release_at);
      key = 1'b0;
    end
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge_code !== exp_code || bus.addr !== 8'd2 ||
        bus.score !== 16'(exp_score) || bus.combo !== 10'(exp_combo) ||
        bus.max_combo !== 10'(exp_max) || bus.holding !== 1'b0) begin
      errors++;
      $display("FAIL hold_tail_%0d: jv=%b jc=%b addr=%0d score=%0d combo=%0d max=%0d holding=%b, want 1 %b 2 %0d %0d %0d 0",
               release_at, bus.judge_valid, bus.judge_code, bus.addr, bus.score, bus.combo,
               bus.max_combo, bus.holding, exp_code, exp_score, exp_combo, exp_max);
    end
    key = 1'b0;
  endtask

  task automatic test_hold_miss();
    clear_rom();
    rom[0] = 16'h4064;
    rom[1] = 16'h8078;
    do_reset();
    do_start();
    goto_frame(107);
    checks++;
    if (bus.judge_valid !== 1'b0 || bus.addr !== 8'd0) begin
      errors++;
      $display("FAIL hold_pre_miss: jv=%b addr=%0d, want 0 0", bus.judge_valid, bus.addr);
    end
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge_code !== 2'b11 || bus.addr !== 8'd2 ||
        bus.busy !== 1'b1 || bus.holding !== 1'b0) begin
      errors++;
      $display("FAIL hold_head_miss: jv=%b jc=%b addr=%0d busy=%b holding=%b, want 1 11 2 1 0",
               bus.judge_valid, bus.judge_code, bus.addr, bus.busy, bus.holding);
    end
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL hold_single_miss: jv=%b done=%b, want 0 1", bus.judge_valid, bus.done);
    end
  endtask

  task automatic test_reset_in_hold();
    clear_rom();
    rom[0] = 16'h4064;
    rom[1] = 16'h8078;
    do_reset();
    do_start();
    goto_frame(100);
    key = 1'b1;
    clk1();
    Reset = 1'b1;
    clk1();
    checks++;
    if ({bus.addr, bus.frame_cnt, bus.judge_valid, bus.judge_code, bus.combo, bus.max_combo,
         bus.score, bus.holding, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_in_hold: addr=%0d frame=%0d jv=%b jc=%b combo=%0d max=%0d score=%0d h/b/d=%b%b%b, want all 0",
               bus.addr, bus.frame_cnt, bus.judge_valid, bus.judge_code, bus.combo, bus.max_combo,
               bus.score, bus.holding, bus.busy, bus.done);
    end
    Reset = 1'b0;
    key = 1'b0;
  endtask

  task automatic test_note_count();
    clear_rom();
    rom[0] = 16'h0005;
    rom[1] = 16'h000A;
    do_reset();
    do_start();
    goto_frame(5);
    key = 1'b1; clk1();
    key = 1'b0;
    goto_frame(10);
    key = 1'b1; clk1();
    key = 1'b0; clk1();
    checks++;
    if (bus2.done !== 1'b1 || bus2.busy !== 1'b0 || bus2.score !== 16'd4 || bus2.combo !== 10'd2 || bus2.addr !== 8'd2) begin
      errors++;
      $display("FAIL count_done: done=%b busy=%b score=%0d combo=%0d addr=%0d, want 1 0 4 2 2",
               bus2.done, bus2.busy, bus2.score, bus2.combo, bus2.addr);
    end
    do_start();
    checks++;
    if (bus2.score !== 16'd0 || bus2.combo !== 10'd0 || bus2.max_combo !== 10'd0 || bus2.addr !== 8'd0 ||
        bus2.frame_cnt !== 14'd0 || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: score=%0d combo=%0d max=%0d addr=%0d frame=%0d busy=%b done=%b, want 0 0 0 0 0 1 0",
               bus2.score, bus2.combo, bus2.max_combo, bus2.addr, bus2.frame_cnt, bus2.busy, bus2.done);
    end
  endtask

  task automatic test_frame_saturate();
    clear_rom();
    rom[0] = 16'h3FFF;
    do_reset();
    do_start();
    goto_frame(16383);
    for (int i = 0; i < 20; i++) begin frame_tick = 1'b1; clk1(); end
    frame_tick = 1'b0;
    checks++;
    if (bus.frame_cnt !== 14'd16383 || bus.judge_valid !== 1'b0 || bus.addr !== 8'd0) begin
      errors++;
      $display("FAIL frame_saturate: frame=%0d jv=%b addr=%0d, want 16383 0 0",
               bus.frame_cnt, bus.judge_valid, bus.addr);
    end
    key = 1'b1;
    clk1();
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge_code !== 2'b01) begin
      errors++;
      $display("FAIL sat_perfect: jv=%b jc=%b, want 1 01", bus.judge_valid, bus.judge_code);
    end
    key = 1'b0;
  endtask

  task automatic test_random();
    int i, tt, r;
    for (int c = 0; c < 3; c++) begin
      clear_rom();
      i = 0;
      tt = 15 + int'($urandom_range(0, 10));
      while (i < 60) begin
        r = int'($urandom_range(0, 9));
        if (r < 6) begin
          rom[i] = {2'b00, 14'(tt)}; i++;
        end else if (r < 9) begin
          rom[i] = {2'b01, 14'(tt)};
          tt = tt + int'($urandom_range(4, 30));
          rom[i+1] = {2'b10, 14'(tt)};
          i += 2;
        end else begin
          rom[i] = {2'b10, 14'(tt)}; i++;
        end
        tt = tt + int'($urandom_range(3, 20));
      end
      do_reset();
      do_start();
      for (int cyc = 0; cyc < 2500 && errors < 50; cyc++) begin
        frame_tick = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) key = ~key;
        start = ($urandom_range(0, 7) == 0);
        Reset = ($urandom_range(0, 1999) == 0);
        clk1();
        checks++;
        if (bus.addr !== 8'(m_addr) || bus.frame_cnt !== 14'(m_frame) || bus.judge_valid !== 1'(m_jv) ||
            bus.judge_code !== 2'(m_jc) || bus.combo !== 10'(m_combo) || bus.max_combo !== 10'(m_max) ||
            bus.score !== 16'(m_score) || bus.holding !== (m_mode == 2) ||
            bus.busy !== (m_mode == 1 || m_mode == 2) || bus.done !== (m_mode == 3)) begin
          errors++;
          $display("FAIL random c%0d cyc%0d: got addr=%0d frame=%0d jv=%b jc=%0d combo=%0d max=%0d score=%0d hbd=%b%b%b want addr=%0d frame=%0d jv=%0d jc=%0d combo=%0d max=%0d score=%0d mode=%0d",
                   c, cyc, bus.addr, bus.frame_cnt, bus.judge_valid, bus.judge_code, bus.combo,
                   bus.max_combo, bus.score, bus.holding, bus.busy, bus.done,
                   m_addr, m_frame, m_jv, m_jc, m_combo, m_max, m_score, m_mode);
        end
      end
      Reset = 1'b0; start = 1'b0; key = 1'b0; frame_tick = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_tap_perfect();
    test_tap_good_and_ignore();
    test_miss_combo();
    test_hold(0,   2'b01, 4, 2, 2);
    test_hold(116, 2'b10, 3, 2, 2);
    test_hold(105, 2'b11, 2, 0, 1);
    test_hold_miss();
    test_reset_in_hold();
    test_note_count();
    test_frame_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
